// File: rtl/execute_forward_unit.sv
// execute_forward_unit
//   Execute/memory-side consumer of decoded instructions. Each cycle one
//   instruction (or a bubble when in_valid=0) is sampled in E. Operands come
//   from the register file or from a 3-deep result history. The ALU executes
//   combinationally, the data-memory port is driven from the M registers, and
//   the write-back value appears from the W registers.
//
//   Ports
//     clk, reset          clock; synchronous active-high reset
//     in_valid            instruction valid (0 = bubble)
//     op_dec[5:0]         opcode, [2:0] selects the ALU function
//     imm[15:0], imm_sel  immediate, 1 = operand B is sign-extended imm
//     mux_sel_A/B[1:0]    operand select: 00 rf, 01 q1, 10 q2, 11 q3
//     mem_rw_ex           1 = store, 0 = load
//     mem_en_ex           instruction accesses data memory
//     mem_mux_sel_dm      1 = write back memory read data
//     rf_data_A/B         register-file read data
//     dm_rdata            combinational memory read data
//     dm_en/rw/addr/wdata data-memory request (registered, M stage)
//     wb_valid, wb_data   write-back (registered, W stage)
module execute_forward_unit #(
  parameter int DW   = 32,
  parameter int HIST = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [5:0]    op_dec,
  input  logic [15:0]   imm,
  input  logic          imm_sel,
  input  logic [1:0]    mux_sel_A,
  input  logic [1:0]    mux_sel_B,
  input  logic          mem_rw_ex,
  input  logic          mem_en_ex,
  input  logic          mem_mux_sel_dm,
  input  logic [DW-1:0] rf_data_A,
  input  logic [DW-1:0] rf_data_B,
  input  logic [DW-1:0] dm_rdata,
  output logic          dm_en,
  output logic          dm_rw,
  output logic [DW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          wb_valid,
  output logic [DW-1:0] wb_data
);

  // History depth is fixed by the 2-bit select encoding.
  localparam int hist_unused = HIST;
  logic [2:0] op_hi_unused;
  assign op_hi_unused = op_dec[5:3];

  logic [DW-1:0] opa, b_fwd, b_alu, imm_ext, alu_res;

  logic [DW-1:0] q1_res_q, q1_res_d;
  logic          q1_v_q, q1_v_d;
  logic          q1_mem_en_q, q1_mem_en_d;
  logic          q1_rw_q, q1_rw_d;
  logic          q1_msel_q, q1_msel_d;
  logic [DW-1:0] q1_wdata_q, q1_wdata_d;
  logic [DW-1:0] q2_res_q, q2_res_d;
  logic          q2_v_q, q2_v_d;
  logic [DW-1:0] q3_res_q, q3_res_d;

  assign imm_ext = {{(DW-16){imm[15]}}, imm};

  always_comb begin
    opa = rf_data_A;
    unique case (mux_sel_A)
      2'b00: opa = rf_data_A;
      2'b01: opa = q1_res_q;
      2'b10: opa = q2_res_q;
      2'b11: opa = q3_res_q;
    endcase
    b_fwd = rf_data_B;
    unique case (mux_sel_B)
      2'b00: b_fwd = rf_data_B;
      2'b01: b_fwd = q1_res_q;
      2'b10: b_fwd = q2_res_q;
      2'b11: b_fwd = q3_res_q;
    endcase
    b_alu = imm_sel ? imm_ext : b_fwd;
  end

  always_comb begin
    alu_res = '0;
    unique case (op_dec[2:0])
      3'b000: alu_res = opa + b_alu;
      3'b001: alu_res = opa - b_alu;
      3'b010: alu_res = opa & b_alu;
      3'b011: alu_res = opa | b_alu;
      3'b100: alu_res = opa ^ b_alu;
      3'b101: alu_res = {{(DW-1){1'b0}}, ($signed(opa) < $signed(b_alu))};
      3'b110: alu_res = opa << b_alu[4:0];
      3'b111: alu_res = b_alu;
    endcase
  end

  always_comb begin
    // Bubbles push a zero result so they still occupy a history slot.
    q1_res_d    = in_valid ? alu_res : '0;
    q1_v_d      = in_valid;
    q1_mem_en_d = mem_en_ex & in_valid;
    q1_rw_d     = mem_rw_ex;
    q1_msel_d   = mem_mux_sel_dm;
    q1_wdata_d  = b_fwd;
    q2_res_d    = (q1_msel_q & q1_mem_en_q & ~q1_rw_q) ? dm_rdata : q1_res_q;
    q2_v_d      = q1_v_q & ~(q1_mem_en_q & q1_rw_q);
    q3_res_d    = q2_res_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q1_res_q    <= '0;
      q1_v_q      <= 1'b0;
      q1_mem_en_q <= 1'b0;
      q1_rw_q     <= 1'b0;
      q1_msel_q   <= 1'b0;
      q1_wdata_q  <= '0;
      q2_res_q    <= '0;
      q2_v_q      <= 1'b0;
      q3_res_q    <= '0;
    end else begin
      q1_res_q    <= q1_res_d;
      q1_v_q      <= q1_v_d;
      q1_mem_en_q <= q1_mem_en_d;
      q1_rw_q     <= q1_rw_d;
      q1_msel_q   <= q1_msel_d;
      q1_wdata_q  <= q1_wdata_d;
      q2_res_q    <= q2_res_d;
      q2_v_q      <= q2_v_d;
      q3_res_q    <= q3_res_d;
    end
  end

  assign dm_en    = q1_mem_en_q;
  assign dm_rw    = q1_rw_q;
  assign dm_addr  = q1_res_q;
  assign dm_wdata = q1_wdata_q;
  assign wb_valid = q2_v_q;
  assign wb_data  = q2_res_q;

endmodule

// File: tb/tb_execute_forward_unit.sv
module tb_execute_forward_unit;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [5:0]    op_dec;
  logic [15:0]   imm;
  logic          imm_sel;
  logic [1:0]    mux_sel_A, mux_sel_B;
  logic          mem_rw_ex, mem_en_ex, mem_mux_sel_dm;
  logic [DW-1:0] rf_data_A, rf_data_B, dm_rdata;
  logic          dm_en, dm_rw, wb_valid;
  logic [DW-1:0] dm_addr, dm_wdata, wb_data;

  typedef struct packed {
    logic          rw;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } dm_t;

  dm_t           dm_q[$];
  logic [DW-1:0] wb_q[$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  execute_forward_unit #(.DW(DW), .HIST(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op_dec(op_dec),
    .imm(imm), .imm_sel(imm_sel), .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B),
    .mem_rw_ex(mem_rw_ex), .mem_en_ex(mem_en_ex), .mem_mux_sel_dm(mem_mux_sel_dm),
    .rf_data_A(rf_data_A), .rf_data_B(rf_data_B), .dm_rdata(dm_rdata),
    .dm_en(dm_en), .dm_rw(dm_rw), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .wb_valid(wb_valid), .wb_data(wb_data)
  );

  // Memory model: 0x40 holds 0xABCD, everything else reads a tagged pattern.
  always_comb dm_rdata = (dm_addr == 32'h40) ? 32'h0000ABCD : (32'h5A5A0000 | dm_addr);

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a memory request
  // or a write-back.
  always @(negedge clk) begin
    dm_t           e;
    logic [DW-1:0] w;
    if (dm_en === 1'b1) begin
      checks++;
      if (dm_q.size() == 0) begin
        errors++;
        $display("FAIL dm_unexpected: got rw=%b addr=%h wdata=%h want none", dm_rw, dm_addr, dm_wdata);
      end else begin
        e = dm_q.pop_front();
        if ({dm_rw, dm_addr, dm_wdata} !== e) begin
          errors++;
          $display("FAIL dm_req: got rw=%b addr=%h wdata=%h want rw=%b addr=%h wdata=%h",
                   dm_rw, dm_addr, dm_wdata, e.rw, e.addr, e.wdata);
        end
      end
    end
    if (wb_valid === 1'b1) begin
      checks++;
      if (wb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got %h want none", wb_data);
      end else begin
        w = wb_q.pop_front();
        if (wb_data !== w) begin
          errors++;
          $display("FAIL wb_data: got %h want %h", wb_data, w);
        end
      end
    end
  end

  // Drives one instruction for one cycle and records what it must produce.
  task automatic issue(input logic [5:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [1:0] sa, input logic [1:0] sb, input logic is,
                       input logic [15:0] im, input logic men, input logic mrw, input logic msel,
                       input logic [DW-1:0] exp_res, input logic [DW-1:0] exp_wd,
                       input logic [DW-1:0] exp_wb);
    in_valid = 1'b1; op_dec = op; rf_data_A = a; rf_data_B = b;
    mux_sel_A = sa; mux_sel_B = sb; imm_sel = is; imm = im;
    mem_en_ex = men; mem_rw_ex = mrw; mem_mux_sel_dm = msel;
    if (men) dm_q.push_back({mrw, exp_res, exp_wd});
    if (!(men && mrw)) wb_q.push_back(exp_wb);
    @(posedge clk); #1;
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0; op_dec = '0; rf_data_A = '0; rf_data_B = '0;
      mux_sel_A = '0; mux_sel_B = '0; imm_sel = 1'b0; imm = '0;
      mem_en_ex = 1'b1; mem_rw_ex = 1'b1; mem_mux_sel_dm = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b1; op_dec = 6'd0; imm = 16'd0; imm_sel = 1'b0;
    mux_sel_A = '0; mux_sel_B = '0;
    mem_rw_ex = 1'b0; mem_en_ex = 1'b1; mem_mux_sel_dm = 1'b0;
    rf_data_A = 32'h11; rf_data_B = 32'h22;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_en", {31'd0, dm_en}, 32'd0);
    chk("rst_dm_rw", {31'd0, dm_rw}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    reset = 1'b0;
    bubble(1);

    // ADD from register file
    issue(6'o00, 32'd5, 32'd7, 2'b00, 2'b00, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 32'd12, 32'd0, 32'd12);
    chk("add_dm_addr", dm_addr, 32'd12);
    bubble(1);

    // Back-to-back ADDI chain, distance 1 and 2 forwarding
    issue(6'o00, 32'd1, 32'h55, 2'b00, 2'b00, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    issue(6'o00, 32'h55, 32'h55, 2'b01, 2'b00, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 32'd3, 32'd0, 32'd3);
    issue(6'o01, 32'h55, 32'h55, 2'b10, 2'b01, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0,
          32'hFFFFFFFD, 32'd0, 32'hFFFFFFFD);

    // Distance 3 forwarding
    issue(6'o07, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 16'd10, 1'b0, 1'b0, 1'b0, 32'd10, 32'd0, 32'd10);
    issue(6'o07, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 16'd20, 1'b0, 1'b0, 1'b0, 32'd20, 32'd0, 32'd20);
    issue(6'o07, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 16'd30, 1'b0, 1'b0, 1'b0, 32'd30, 32'd0, 32'd30);
    issue(6'o03, 32'h77, 32'h77, 2'b11, 2'b10, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 32'h1E, 32'd0, 32'h1E);

    // Remaining ALU functions; opcode upper bits must not matter
    issue(6'o02, 32'hF0F0, 32'hFF00, 2'b00, 2'b00, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 32'hF000, 32'd0, 32'hF000);
    issue(6'o74, 32'hFF, 32'h0F, 2'b00, 2'b00, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 32'hF0, 32'd0, 32'hF0);
    issue(6'o05, 32'hFFFFFFFF, 32'd1, 2'b00, 2'b00, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 32'd1);
    issue(6'o05, 32'd1, 32'hFFFFFFFF, 2'b00, 2'b00, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    issue(6'o06, 32'd1, 32'h24, 2'b00, 2'b00, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 32'h10);
    issue(6'o00, 32'd9, 32'd0, 2'b00, 2'b00, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0,
          32'hFFFF8009, 32'd0, 32'hFFFF8009);

    // Store: no write-back
    issue(6'o07, 32'h0, 32'hCAFE, 2'b00, 2'b00, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0,
          32'hCAFE, 32'hCAFE, 32'd0);

    // Load, bubble, consumer at distance 2
    issue(6'o00, 32'h40, 32'h0, 2'b00, 2'b00, 1'b1, 16'd0, 1'b1, 1'b0, 1'b1,
          32'h40, 32'h0, 32'hABCD);
    bubble(1);
    issue(6'o00, 32'h99, 32'h99, 2'b10, 2'b00, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0,
          32'hABCD, 32'd0, 32'hABCD);
    // Load without memory select writes back the address
    issue(6'o00, 32'h80, 32'h1234, 2'b00, 2'b00, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0,
          32'h80, 32'h1234, 32'h80);
    bubble(3);

    // Reset while a load sits in M; the instruction sampled with reset is dropped
    issue(6'o00, 32'h40, 32'h0, 2'b00, 2'b00, 1'b1, 16'd0, 1'b1, 1'b0, 1'b1,
          32'h40, 32'h0, 32'hABCD);
    reset = 1'b1;
    in_valid = 1'b1; op_dec = 6'o00; rf_data_A = 32'h40; mem_en_ex = 1'b1; mem_rw_ex = 1'b0;
    @(posedge clk); #1;
    wb_q.delete();
    chk("rst2_dm_en", {31'd0, dm_en}, 32'd0);
    chk("rst2_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst2_dm_addr", dm_addr, 32'd0);
    chk("rst2_wb_data", wb_data, 32'd0);
    reset = 1'b0;
    issue(6'o00, 32'h33, 32'h0, 2'b01, 2'b00, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 32'd5);
    issue(6'o00, 32'h33, 32'h0, 2'b10, 2'b00, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 32'd5);
    issue(6'o00, 32'h33, 32'h0, 2'b11, 2'b00, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 32'd5);
    bubble(4);

    chk("dm_q_drained", dm_q.size(), 32'd0);
    chk("wb_q_drained", wb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
